fp_frac_to_dec_seq: RTL and testbench

//  Iterative binary-fraction to decimal-scientific converter for the float-to-number path (negative-exponent side).

---
 rtl/fp_frac_to_dec_seq.sv | 207 ++++++++++++++++++++
 tb/tb_fp_frac_to_dec_seq.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/fp_frac_to_dec_seq.sv
// Iterative binary-fraction to decimal-scientific converter: frac * 2^-exp -> int_part.digits x 10^dec_exp.
// Optional round-half-up on a guard digit when the ROUND_EN macro is defined (default: truncate).
module fp_frac_to_dec_seq #(
  parameter int unsigned FRAC_W = 28,
  parameter int unsigned INT_W  = 4,
  parameter int unsigned EXP_W  = 9,
  parameter int unsigned NDIG   = 6,
  parameter int unsigned DEXP_W = 9
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                start,
  input  logic [FRAC_W-1:0]   frac,
  input  logic [EXP_W-1:0]    exp,
  output logic                busy,
  output logic                done,
  output logic                zero,
  output logic [INT_W-1:0]    int_part,
  output logic [4*NDIG-1:0]   digits,
  output logic [DEXP_W-1:0]   dec_exp
);

  localparam int unsigned F     = FRAC_W - INT_W;
  localparam int unsigned DIG_W = 4 * NDIG;
`ifdef ROUND_EN
  localparam int unsigned NRUN  = NDIG + 1;
`else
  localparam int unsigned NRUN  = NDIG;
`endif
  localparam int unsigned CNT_W = (NRUN < 2) ? 1 : $clog2(NRUN + 1);

`ifdef ROUND_EN
  typedef enum logic [2:0] {S_IDLE, S_NORM, S_DIGIT, S_ROUND, S_DONE} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_NORM, S_DIGIT, S_DONE} state_t;
`endif

  state_t              state, state_nxt;
  logic [FRAC_W-1:0]   v, v_nxt;
  logic [EXP_W-1:0]    steps, steps_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic                busy_nxt, done_nxt, zero_nxt;
  logic [INT_W-1:0]    int_part_nxt;
  logic [DIG_W-1:0]    digits_nxt;
  logic [DEXP_W-1:0]   dec_exp_nxt;

  logic [FRAC_W-1:0]   v_sh, v_mul;
  logic [EXP_W-1:0]    steps_sh;
  logic                mul_hit;
  logic [F+3:0]        f_mul;
  logic [3:0]          dig;

`ifdef ROUND_EN
  logic [3:0]          guard, guard_nxt;
  logic [DIG_W-1:0]    dig_r;
  logic                carry;
`endif

  // State and datapath registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= S_IDLE;
      v        <= '0;
      steps    <= '0;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      zero     <= 1'b0;
      int_part <= '0;
      digits   <= '0;
      dec_exp  <= '0;
`ifdef ROUND_EN
      guard    <= '0;
`endif
    end else begin
      state    <= state_nxt;
      v        <= v_nxt;
      steps    <= steps_nxt;
      cnt      <= cnt_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
      zero     <= zero_nxt;
      int_part <= int_part_nxt;
      digits   <= digits_nxt;
      dec_exp  <= dec_exp_nxt;
`ifdef ROUND_EN
      guard    <= guard_nxt;
`endif
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_nxt    = state;
    v_nxt        = v;
    steps_nxt    = steps;
    cnt_nxt      = cnt;
    busy_nxt     = busy;
    done_nxt     = 1'b0;
    zero_nxt     = zero;
    int_part_nxt = int_part;
    digits_nxt   = digits;
    dec_exp_nxt  = dec_exp;
`ifdef ROUND_EN
    guard_nxt    = guard;
    dig_r        = digits;
    carry        = 1'b0;
`endif

    // One halving step, then renormalise by x10 while the value is below 1.0
    v_sh     = (steps != '0) ? (v >> 1) : v;
    steps_sh = (steps != '0) ? (steps - EXP_W'(1)) : steps;
    mul_hit  = (v_sh[FRAC_W-1 -: INT_W] == '0) && (v_sh != '0);
    v_mul    = mul_hit ? ((v_sh << 3) + (v_sh << 1)) : v_sh;

    f_mul = ({4'b0000, v[F-1:0]} << 3) + ({4'b0000, v[F-1:0]} << 1);
    dig   = f_mul[F+3:F];

    case (state)
      S_IDLE, S_DONE: begin
        done_nxt = (state == S_DONE);
        if (state == S_DONE) begin
          busy_nxt  = 1'b0;
          state_nxt = S_IDLE;
        end
        if (start) begin
          v_nxt        = frac;
          steps_nxt    = exp;
          dec_exp_nxt  = '0;
          cnt_nxt      = '0;
          zero_nxt     = 1'b0;
          int_part_nxt = '0;
          digits_nxt   = '0;
          busy_nxt     = 1'b1;
          if (frac == '0) begin
            zero_nxt  = 1'b1;
            state_nxt = S_DONE;
          end else if ((exp == '0) && (frac[FRAC_W-1 -: INT_W] != '0)) begin
            int_part_nxt = frac[FRAC_W-1 -: INT_W];
            state_nxt    = S_DIGIT;
          end else begin
            state_nxt = S_NORM;
          end
        end
      end

      S_NORM: begin
        v_nxt     = v_mul;
        steps_nxt = steps_sh;
        if (mul_hit) dec_exp_nxt = dec_exp - DEXP_W'(1);
        // A value shifted all the way to zero exits too, so NORM always terminates
        if ((steps_sh == '0) && ((v_mul[FRAC_W-1 -: INT_W] != '0) || (v_mul == '0))) begin
          int_part_nxt = v_mul[FRAC_W-1 -: INT_W];
          state_nxt    = S_DIGIT;
        end
      end

      S_DIGIT: begin
        v_nxt   = {{INT_W{1'b0}}, f_mul[F-1:0]};
        cnt_nxt = cnt + CNT_W'(1);
`ifdef ROUND_EN
        if (cnt == CNT_W'(NDIG)) begin
          guard_nxt = dig;
          state_nxt = S_ROUND;
        end else begin
          digits_nxt = (digits << 4) | DIG_W'(dig);
        end
`else
        digits_nxt = (digits << 4) | DIG_W'(dig);
        if (cnt == CNT_W'(NDIG - 1)) state_nxt = S_DONE;
`endif
      end

`ifdef ROUND_EN
      S_ROUND: begin
        state_nxt = S_DONE;
        if (guard >= 4'd5) begin
          carry = 1'b1;
          for (int i = 0; i < NDIG; i++) begin
            if (carry) begin
              if (dig_r[4*i +: 4] == 4'd9) begin
                dig_r[4*i +: 4] = 4'd0;
              end else begin
                dig_r[4*i +: 4] = dig_r[4*i +: 4] + 4'd1;
                carry = 1'b0;
              end
            end
          end
          digits_nxt = dig_r;
          if (carry) begin
            if (int_part == INT_W'(9)) begin
              int_part_nxt = INT_W'(1);
              digits_nxt   = '0;
              dec_exp_nxt  = dec_exp + DEXP_W'(1);
            end else begin
              int_part_nxt = int_part + INT_W'(1);
            end
          end
        end
      end
`endif

      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_fp_frac_to_dec_seq.sv
// Directed bench for fp_frac_to_dec_seq: latency, results, abort and busy-start handling.
// Under ROUND_EN a second NDIG=1 instance also exercises rounding.
module tb_fp_frac_to_dec_seq;

  logic        CLK = 1'b0;
  logic        RST;
  logic        start;
  logic [27:0] frac;
  logic [8:0]  exp;
  logic        busy, done, zero;
  logic [3:0]  int_part;
  logic [23:0] digits;
  logic [8:0]  dec_exp;

  int checks = 0;
  int errors = 0;

`ifdef ROUND_EN
  localparam int EXTRA = 2;
`else
  localparam int EXTRA = 0;
`endif
  localparam logic [27:0] ONE = 28'h1000000;

  always #5 CLK = ~CLK;

  fp_frac_to_dec_seq dut (
    .CLK(CLK), .RST(RST), .start(start), .frac(frac), .exp(exp),
    .busy(busy), .done(done), .zero(zero), .int_part(int_part),
    .digits(digits), .dec_exp(dec_exp)
  );

`ifdef ROUND_EN
  logic        busy_r, done_r, zero_r;
  logic [3:0]  int_part_r;
  logic [3:0]  digits_r;
  logic [8:0]  dec_exp_r;

  fp_frac_to_dec_seq #(.NDIG(1)) dut_r (
    .CLK(CLK), .RST(RST), .start(start), .frac(frac), .exp(exp),
    .busy(busy_r), .done(done_r), .zero(zero_r), .int_part(int_part_r),
    .digits(digits_r), .dec_exp(dec_exp_r)
  );
`endif

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic convert(input string tag, input logic [27:0] f, input logic [8:0] e,
                         input int lat, input logic z, input logic [3:0] ip,
                         input logic [23:0] dg, input int de, input bit poke);
    int n;
    logic seen;
    logic [8:0] de_e;
    de_e = 9'(de);
    @(negedge CLK);
    frac = f; exp = e; start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0; frac = 28'hABCDEF1; exp = 9'h1AB;
    check({tag, " busy_after_accept"}, busy, 1);
    n = 0; seen = 1'b0;
    while (!seen && n < 400) begin
      if (poke && n == 3) begin
        start = 1'b1; frac = '0; exp = '0;
      end else begin
        start = 1'b0;
      end
      @(posedge CLK); #1;
      n++;
      seen = done;
    end
    start = 1'b0;
    check({tag, " done_edge"}, 64'(n), 64'(lat));
    check({tag, " zero"}, zero, z);
    check({tag, " int_part"}, int_part, ip);
    check({tag, " digits"}, digits, dg);
    check({tag, " dec_exp"}, dec_exp, de_e);
    check({tag, " busy_at_done"}, busy, 0);
    @(posedge CLK); #1;
    check({tag, " done_pulse_width"}, done, 0);
    check({tag, " digits_held"}, digits, dg);
  endtask

`ifdef ROUND_EN
  task automatic convert_r(input string tag, input logic [27:0] f, input logic [8:0] e,
                           input int lat, input logic [3:0] ip, input logic [3:0] dg, input int de);
    int n;
    logic seen;
    logic [8:0] de_e;
    de_e = 9'(de);
    @(negedge CLK);
    frac = f; exp = e; start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    n = 0; seen = 1'b0;
    while (!seen && n < 400) begin
      @(posedge CLK); #1;
      n++;
      seen = done_r;
    end
    check({tag, " done_edge"}, 64'(n), 64'(lat));
    check({tag, " int_part"}, int_part_r, ip);
    check({tag, " digits"}, digits_r, dg);
    check({tag, " dec_exp"}, dec_exp_r, de_e);
    repeat (30) @(posedge CLK);
    #1;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int ndone;
    RST = 1'b1; start = 1'b0; frac = '0; exp = '0;
    #12;
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset zero", zero, 0);
    check("reset int_part", int_part, 0);
    check("reset digits", digits, 0);
    check("reset dec_exp", dec_exp, 0);
    @(negedge CLK); RST = 1'b0;

    convert("half",      ONE,          9'd1, 8  + EXTRA, 1'b0, 4'd5, 24'h000000, -1, 1'b0);
    convert("exp7_poke", ONE,          9'd7, 14 + EXTRA, 1'b0, 4'd7, 24'h812500, -3, 1'b1);
    convert("sixteenth", 28'h0100000,  9'd0, 9  + EXTRA, 1'b0, 4'd6, 24'h250000, -2, 1'b0);
    convert("zero",      28'h0000000,  9'd5, 1,          1'b1, 4'd0, 24'h000000,  0, 1'b0);
    convert("nines",     28'h9F80000,  9'd0, 7  + EXTRA, 1'b0, 4'd9, 24'h968750,  0, 1'b0);
    convert("three",     28'h3000000,  9'd2, 9  + EXTRA, 1'b0, 4'd7, 24'h500000, -1, 1'b0);
    convert("lsb",       28'h0000001,  9'd0, 15 + EXTRA, 1'b0, 4'd5, 24'h960464, -8, 1'b0);

    // Abort mid-NORM: three NORM cycles have run (5.0 -> 2.5 -> 1.25, dec_exp=-1)
    @(negedge CLK);
    frac = ONE; exp = 9'd7; start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check("abort pre busy", busy, 1);
    check("abort pre dec_exp", dec_exp, 9'h1FF);
    #1 RST = 1'b1;
    #1;
    check("abort busy", busy, 0);
    check("abort done", done, 0);
    check("abort int_part", int_part, 0);
    check("abort digits", digits, 0);
    check("abort dec_exp", dec_exp, 0);
    @(negedge CLK); RST = 1'b0;
    ndone = 0;
    repeat (30) begin
      @(posedge CLK); #1;
      if (done) ndone++;
    end
    check("abort no_done", 64'(ndone), 0);
    convert("after_abort", ONE, 9'd1, 8 + EXTRA, 1'b0, 4'd5, 24'h000000, -1, 1'b0);

`ifdef ROUND_EN
    convert_r("round_1p25", ONE,         9'd3, 7, 4'd1, 4'd3, -1);
    convert_r("round_carry", 28'h9F80000, 9'd0, 4, 4'd1, 4'd0,  1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
